ccip_c0_rd_arb: RTL

CCIP_C0_RD_ARB -- requirements
Module: ccip_c0_rd_arb

---
 rtl/ccip_c0_rd_arb_pkg.sv | 18 +
 rtl/ccip_rr_arbiter.sv | 22 ++
 rtl/ccip_c0_rd_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ccip_c0_rd_arb_pkg.sv
// Shared types and field widths for the c0 read arbiter.
// Requester ID travels in the top two mdata bits.
package ccip_c0_rd_arb_pkg;

  localparam int ADDR_W  = 42;
  localparam int TAG_W   = 14;
  localparam int MDATA_W = 16;
  localparam int RID_MSB = 15;
  localparam int RID_LSB = 14;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    DRAIN,
    DRAINED
  } state_e;

endpackage

// File: rtl/ccip_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr_i, wrapping.
// Output is one-hot and all-zero when en_i is low.
module ccip_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] valid_i,
  input  logic [1:0]   ptr_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi;
  logic [N-1:0] pick;

  assign hi_mask = ~((N'(1) << ptr_i) - N'(1));
  assign hi      = valid_i & hi_mask;
  assign pick    = (|hi) ? hi : valid_i;
  // Isolate lowest set bit of the chosen half.
  assign grant_o = en_i ? (pick & (~pick + N'(1))) : '0;

endmodule

// File: rtl/ccip_c0_rd_arb.sv
// CCI-P c0 read arbiter: round-robin requesters onto c0 Tx, route c0 Rx.
// Define CCIP_C0_RD_ARB_STATS_EN to add per-requester grant counters.
module ccip_c0_rd_arb
  import ccip_c0_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c0_almfull,
  output logic                      c0tx_valid,
  output logic [ADDR_W-1:0]         c0tx_addr,
  output logic [MDATA_W-1:0]        c0tx_mdata,
  input  logic                      c0rx_valid,
  input  logic [MDATA_W-1:0]        c0rx_mdata,
  input  logic [511:0]              c0rx_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [511:0]              rsp_data,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [7:0]                outstanding
`ifdef CCIP_C0_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt
`endif
);

  state_e              state_q;
  logic                done_q;
  logic [1:0]          rr_ptr_q;
  logic [7:0]          out_q, out_d;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  rsp_d;
  logic [1:0]          gidx;
  logic [ADDR_W-1:0]   addr_sel;
  logic [TAG_W-1:0]    tag_sel;
  logic                full, gate, acc;
  logic                tx_v_q;
  logic [ADDR_W-1:0]   tx_addr_q;
  logic [MDATA_W-1:0]  tx_md_q;
  logic [NUM_REQ-1:0]  rsp_v_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic [511:0]        rsp_data_q;

  assign full = (out_q == 8'(MAX_OUTSTANDING));
  assign gate = (state_q == RUN) && !c0_almfull && !full;

  ccip_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (gate),
    .grant_o (grant)
  );

  // Held low during reset even though the FSM sits in RUN.
  assign req_ready = grant & {NUM_REQ{reset_n}};
  assign acc       = |grant;

  always_comb begin
    gidx     = '0;
    addr_sel = '0;
    tag_sel  = '0;
    rsp_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx     = 2'(i);
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        tag_sel  = req_tag[i*TAG_W +: TAG_W];
      end
      rsp_d[i] = c0rx_valid &&
        (c0rx_mdata[RID_MSB:RID_LSB] == 2'(i));
    end
  end

  always_comb begin
    out_d = out_q;
    unique case ({acc, c0rx_valid})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = (out_q == '0) ? '0 : out_q - 8'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN, HOLD: begin
          if (drain_req)               state_q <= DRAIN;
          else if (c0_almfull || full) state_q <= HOLD;
          else                         state_q <= RUN;
        end
        DRAIN: begin
          if (out_q == '0) begin
            state_q <= DRAINED;
            done_q  <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state_q <= RUN;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      out_q      <= '0;
      tx_v_q     <= 1'b0;
      tx_addr_q  <= '0;
      tx_md_q    <= '0;
      rsp_v_q    <= '0;
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      out_q   <= out_d;
      tx_v_q  <= acc;
      rsp_v_q <= rsp_d;
      if (acc) begin
        rr_ptr_q  <= (gidx == 2'(NUM_REQ-1)) ? 2'd0 : gidx + 2'd1;
        tx_addr_q <= addr_sel;
        tx_md_q   <= {gidx, tag_sel};
      end
      if (c0rx_valid) begin
        rsp_tag_q  <= c0rx_mdata[TAG_W-1:0];
        rsp_data_q <= c0rx_data;
      end
    end
  end

  assign c0tx_valid  = tx_v_q;
  assign c0tx_addr   = tx_addr_q;
  assign c0tx_mdata  = tx_md_q;
  assign rsp_valid   = rsp_v_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_data    = rsp_data_q;
  assign drain_done  = done_q;
  assign outstanding = out_q;

`ifdef CCIP_C0_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
